// File: rtl/int_sequencer_pkg.sv
// rtl/int_sequencer_pkg.sv - shared constants, state type and width helper for the interrupt sequencer
package int_sequencer_pkg;

    localparam logic [15:0] INT_VECTOR_BASE = 16'hFFFA;

    // Source indices; lower index wins arbitration.
    localparam int INT_NMI = 0;
    localparam int INT_RES = 1;
    localparam int INT_IRQ = 2;

    typedef enum logic [1:0] {
        INT_IDLE     = 2'd0,
        INT_FETCH_LO = 2'd1,
        INT_FETCH_HI = 2'd2,
        INT_DONE     = 2'd3
    } int_state_t;

    // Width of a source index; never narrower than one bit.
    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - lowest-index-first priority encoder over the eligible request vector
module int_prio_enc
    import int_sequencer_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int SRC_W   = src_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] eligible, // one bit per source
    output logic               any,      // at least one bit set
    output logic [SRC_W-1:0]   idx       // lowest set index, 0 when none
);

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        any = |eligible;
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                idx = SRC_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_sequencer.sv
// rtl/int_sequencer.sv - arbitrates interrupt sources and fetches the 2-byte vector of the winner
module int_sequencer
    import int_sequencer_pkg::*;
#(
    parameter int                    NUM_SRC     = 3,
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] VECTOR_BASE = INT_VECTOR_BASE,
    parameter logic [NUM_SRC-1:0]    EDGE_MASK   = 3'b001,
    parameter logic [NUM_SRC-1:0]    MASK_EN     = 3'b100
) (
    input  logic                         clk,          // rising-edge clock
    input  logic                         reset,        // async, active high
    input  logic [NUM_SRC-1:0]           src_n,        // active-low requests
    input  logic                         i_flag,       // status I bit
    input  logic                         boundary,     // instruction boundary
    output logic                         mem_rd,       // read request, held until mem_valid
    output logic [ADDR_WIDTH-1:0]        mem_addr,     // read address
    input  logic [DATA_WIDTH-1:0]        mem_data,     // read data
    input  logic                         mem_valid,    // completes current read
    output logic                         int_pending,  // some source eligible
    output logic                         busy,         // not idle
    output logic [ADDR_WIDTH-1:0]        vector,       // fetched vector
    output logic [src_w(NUM_SRC)-1:0]    vector_src,   // serviced source
    output logic                         vector_valid  // one-cycle strobe
);

    localparam int SRC_W = src_w(NUM_SRC);

    int_state_t          state;
    logic [NUM_SRC-1:0]  prev_n;
    logic [NUM_SRC-1:0]  pend;
    logic [SRC_W-1:0]    sel;
    logic [DATA_WIDTH-1:0] lo_byte;

    logic [NUM_SRC-1:0]  pending;
    logic [NUM_SRC-1:0]  eligible;
    logic [NUM_SRC-1:0]  pend_set;
    logic [NUM_SRC-1:0]  pend_clr;
    logic                enc_any;
    logic [SRC_W-1:0]    enc_idx;
    logic [ADDR_WIDTH-1:0] lo_addr;

    // Edge sources report the latch, level sources report the pin directly.
    assign pending  = (EDGE_MASK & pend) | (~EDGE_MASK & ~src_n);
    assign eligible = pending & ~(MASK_EN & {NUM_SRC{i_flag}});
    assign pend_set = EDGE_MASK & prev_n & ~src_n;
    assign pend_clr = (state == INT_DONE) ? (NUM_SRC'(1) << sel) : '0;
    assign lo_addr  = VECTOR_BASE + (ADDR_WIDTH'(enc_idx) << 1);

    assign int_pending = enc_any;
    assign busy        = (state != INT_IDLE);

    int_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_prio_enc (
        .eligible (eligible),
        .any      (enc_any),
        .idx      (enc_idx)
    );

    // A new falling edge in the same cycle as the DONE clear keeps the latch set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_n <= '1;
            pend   <= '0;
        end else begin
            prev_n <= src_n;
            pend   <= (pend & ~pend_clr) | pend_set;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= INT_IDLE;
            sel          <= '0;
            lo_byte      <= '0;
            mem_rd       <= 1'b0;
            mem_addr     <= '0;
            vector       <= '0;
            vector_src   <= '0;
            vector_valid <= 1'b0;
        end else begin
            vector_valid <= 1'b0;
            case (state)
                INT_IDLE: begin
                    if (boundary && enc_any) begin
                        sel      <= enc_idx;
                        mem_addr <= lo_addr;
                        mem_rd   <= 1'b1;
                        state    <= INT_FETCH_LO;
                    end
                end
                INT_FETCH_LO: begin
                    if (mem_valid) begin
                        lo_byte  <= mem_data;
                        mem_addr <= mem_addr + ADDR_WIDTH'(1);
                        state    <= INT_FETCH_HI;
                    end
                end
                INT_FETCH_HI: begin
                    if (mem_valid) begin
                        vector       <= ADDR_WIDTH'({mem_data, lo_byte});
                        vector_src   <= sel;
                        vector_valid <= 1'b1;
                        mem_rd       <= 1'b0;
                        state        <= INT_DONE;
                    end
                end
                INT_DONE: begin
                    state <= INT_IDLE;
                end
                default: begin
                    state <= INT_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_sequencer.sv
// tb/tb_int_sequencer.sv - randomized and directed self-checking bench for int_sequencer
module tb_int_sequencer;
    import int_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  src_n;
    logic        i_flag;
    logic        boundary;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_valid;
    logic        int_pending;
    logic        busy;
    logic [15:0] vector;
    logic [1:0]  vector_src;
    logic        vector_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] edge_cfg = 3'b001;
    logic [2:0] mask_cfg = 3'b100;
    logic [7:0] mem [6];

    bit          m_prev_n [3];
    bit          m_pend   [3];
    bit          m_idle;
    bit          m_done;
    int          m_sel;
    logic [15:0] m_addr_q [$];
    logic [7:0]  m_bytes  [$];

    int_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .src_n        (src_n),
        .i_flag       (i_flag),
        .boundary     (boundary),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_valid    (mem_valid),
        .int_pending  (int_pending),
        .busy         (busy),
        .vector       (vector),
        .vector_src   (vector_src),
        .vector_valid (vector_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_at(input logic [15:0] a);
        logic [15:0] off;
        off = a - 16'hFFFA;
        return (off < 16'd6) ? mem[off[2:0]] : 8'h00;
    endfunction

    function automatic logic [2:0] model_elig();
        logic [2:0] e;
        bit req;
        for (int i = 0; i < 3; i++) begin
            req  = edge_cfg[i] ? m_pend[i] : !src_n[i];
            e[i] = req && !(mask_cfg[i] && i_flag);
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_prev_n[i] = 1'b1;
            m_pend[i]   = 1'b0;
        end
        m_idle = 1'b1;
        m_done = 1'b0;
        m_sel  = 0;
        m_addr_q.delete();
        m_bytes.delete();
    endtask

    // Transaction-level view: a service is a list of two reads then one result strobe.
    task automatic model_edge();
        logic [2:0] e;
        logic [15:0] base;
        e = model_elig();
        if (m_done) begin
            m_done = 1'b0;
            m_idle = 1'b1;
            m_pend[m_sel] = 1'b0;
        end else if (m_idle) begin
            if (boundary && e != 3'b000) begin
                for (int i = 2; i >= 0; i--) if (e[i]) m_sel = i;
                base = 16'hFFFA + 16'(2 * m_sel);
                m_addr_q.push_back(base);
                m_addr_q.push_back(base + 16'd1);
                m_bytes.delete();
                m_idle = 1'b0;
            end
        end else if (m_addr_q.size() > 0 && mem_valid) begin
            m_bytes.push_back(mem_at(m_addr_q.pop_front()));
            if (m_addr_q.size() == 0) m_done = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            if (edge_cfg[i] && m_prev_n[i] && !src_n[i]) m_pend[i] = 1'b1;
            m_prev_n[i] = src_n[i];
        end
    endtask

    // Called at posedge+1; drives one cycle of inputs, advances one edge, checks the result.
    task automatic step(input logic [2:0] s_n, input logic iflag, input logic bnd, input logic mv);
        bit exp_rd;
        src_n     = s_n;
        i_flag    = iflag;
        boundary  = bnd;
        mem_valid = mv;
        mem_data  = mem_at(mem_addr);
        #1;
        check_eq("int_pending", int_pending, model_elig() != 3'b000);
        @(posedge clk);
        model_edge();
        #1;
        exp_rd = !m_idle && m_addr_q.size() > 0;
        check_eq("busy", busy, !m_idle);
        check_eq("mem_rd", mem_rd, exp_rd);
        if (exp_rd) check_eq("mem_addr", mem_addr, m_addr_q[0]);
        check_eq("vector_valid", vector_valid, m_done);
        if (m_done) begin
            check_eq("vector", vector, {m_bytes[1], m_bytes[0]});
            check_eq("vector_src", vector_src, m_sel);
        end
    endtask

    task automatic do_reset();
        src_n     = 3'b111;
        boundary  = 1'b0;
        mem_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        check_eq("rst_mem_rd", mem_rd, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_vector", vector, 0);
        check_eq("rst_vector_src", vector_src, 0);
        check_eq("rst_vector_valid", vector_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_int_pending", int_pending, 0);
        #1 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [2:0] cur;
        logic       fl;
        reset = 1'b1; src_n = 3'b111; i_flag = 1'b0; boundary = 1'b0;
        mem_valid = 1'b0; mem_data = 8'h00;
        mem[0] = 8'hCD; mem[1] = 8'hAB; mem[2] = 8'h78;
        mem[3] = 8'h56; mem[4] = 8'h34; mem[5] = 8'h12;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Level IRQ, zero wait: reads FFFE/FFFF, vector 1234 at k+3.
        step(3'b011, 0, 1, 1);
        check_eq("irq_lo_addr", mem_addr, 16'hFFFE);
        step(3'b011, 0, 0, 1);
        check_eq("irq_hi_addr", mem_addr, 16'hFFFF);
        step(3'b011, 0, 0, 1);
        check_eq("irq_vv", vector_valid, 1);
        check_eq("irq_vector", vector, 16'h1234);
        check_eq("irq_src", vector_src, INT_IRQ);
        step(3'b111, 0, 0, 0);

        // Masked IRQ is invisible, then serviced once I clears.
        repeat (3) step(3'b011, 1, 1, 1);
        check_eq("masked_no_rd", mem_rd, 0);
        step(3'b011, 0, 0, 0);
        step(3'b011, 0, 1, 1);
        check_eq("unmasked_addr", mem_addr, 16'hFFFE);
        repeat (3) step(3'b111, 0, 0, 1);

        // NMI pulse while not at a boundary, then 3 wait cycles on the low read.
        step(3'b110, 0, 0, 0);
        repeat (5) step(3'b111, 0, 0, 0);
        step(3'b111, 0, 1, 0);
        for (int w = 0; w < 3; w++) begin
            check_eq("wait_addr_hold", mem_addr, 16'hFFFA);
            step(3'b111, 0, 0, 0);
        end
        step(3'b111, 0, 0, 1);
        check_eq("nmi_hi_addr", mem_addr, 16'hFFFB);
        step(3'b111, 0, 0, 1);
        check_eq("nmi_vv_k6", vector_valid, 1);
        check_eq("nmi_vector", vector, 16'hABCD);
        check_eq("nmi_src", vector_src, INT_NMI);
        step(3'b111, 0, 0, 0);

        // NMI edge and IRQ together: NMI first, then IRQ at the next boundary.
        step(3'b010, 0, 0, 0);
        step(3'b010, 0, 1, 1);
        step(3'b010, 0, 0, 1);
        step(3'b010, 0, 0, 1);
        check_eq("both_first_src", vector_src, INT_NMI);
        step(3'b010, 0, 1, 1);
        step(3'b010, 0, 1, 1);
        check_eq("both_second_addr", mem_addr, 16'hFFFE);
        repeat (3) step(3'b111, 0, 0, 1);

        // Reset in FETCH_HI with an NMI edge latched during the fetch.
        step(3'b011, 0, 1, 1);
        step(3'b010, 0, 0, 1);
        check_eq("pre_rst_hi", mem_addr, 16'hFFFF);
        do_reset();
        step(3'b111, 0, 1, 1);
        check_eq("post_rst_idle", busy, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 6; i++) mem[i] = 8'($urandom);
        cur = 3'b111;
        fl  = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            bit rd_now;
            for (int i = 0; i < 3; i++) if ($urandom_range(3) == 0) cur[i] = ~cur[i];
            if ($urandom_range(7) == 0) fl = ~fl;
            rd_now = !m_idle && m_addr_q.size() > 0;
            step(cur, fl, $urandom_range(2) == 0, $urandom_range(99) < (rd_now ? 60 : 30));
            if ($urandom_range(399) == 0) begin
                do_reset();
                cur = 3'b111;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
